// File: rtl/risc_cpu_pkg.sv
// Shared definitions for the risc_cpu slice: instruction field codes,
// ALU/shift operations, controller states and the shifter helper.
package risc_cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NUM_REGS = 8;

  typedef logic [2:0] reg_idx_t;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // ALU op values line up with the op field of OPC_ALU instructions
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_CMP = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE
  } state_e;

  function automatic logic [15:0] shift_apply(input logic [15:0] b, input logic [1:0] sh);
    logic [15:0] res;
    case (sh)
      SH_LSL:  res = {b[14:0], 1'b0};
      SH_LSR:  res = {1'b0, b[15:1]};
      SH_ASR:  res = {b[15], b[15:1]};
      default: res = b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/risc_cpu_datapath.sv
// Datapath: register file, shifter on the B operand, ALU, A/B/C
// pipeline registers and the N/V/Z status registers.
module risc_cpu_datapath
  import risc_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_a_zero,
  input  logic        i_ld_a,
  input  logic        i_ld_b,
  input  logic        i_ld_c,
  input  logic        i_ld_flags,
  input  logic [1:0]  i_alu_op,
  input  logic [1:0]  i_sh,
  input  logic        i_wr_en,
  input  logic        i_wr_imm,
  input  logic [2:0]  i_wr_addr,
  input  logic [2:0]  i_rd_addr_a,
  input  logic [2:0]  i_rd_addr_b,
  input  logic [7:0]  i_imm8,
  output logic [15:0] o_c,
  output logic        o_n,
  output logic        o_v,
  output logic        o_z
);

  logic [15:0] r_a, r_b, r_c;
  logic        Z_out, V_out, N_out;
  logic [15:0] w_rd_a, w_rd_b, w_wr_data, w_b_sh, w_res;
  logic        w_ovf;

  assign w_wr_data = i_wr_imm ? {{8{i_imm8[7]}}, i_imm8} : r_c;

  risc_cpu_regfile REGFILE (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (w_wr_data),
    .i_rd_addr_a (i_rd_addr_a),
    .i_rd_addr_b (i_rd_addr_b),
    .o_rd_a      (w_rd_a),
    .o_rd_b      (w_rd_b)
  );

  assign w_b_sh = shift_apply(r_b, i_sh);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (alu_op_e'(i_alu_op))
      ALU_ADD: begin
        w_res = r_a + w_b_sh;
        w_ovf = (r_a[15] == w_b_sh[15]) && (w_res[15] != r_a[15]);
      end
      ALU_CMP: begin
        w_res = r_a - w_b_sh;
        w_ovf = (r_a[15] != w_b_sh[15]) && (w_res[15] != r_a[15]);
      end
      ALU_AND: w_res = r_a & w_b_sh;
      default: w_res = ~w_b_sh;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      Z_out <= 1'b0;
      V_out <= 1'b0;
      N_out <= 1'b0;
    end else begin
      if (i_ld_a) r_a <= i_a_zero ? 16'h0000 : w_rd_a;
      if (i_ld_b) r_b <= w_rd_b;
      if (i_ld_c) r_c <= w_res;
      if (i_ld_flags) begin
        Z_out <= (w_res == 16'h0000);
        N_out <= w_res[15];
        V_out <= w_ovf;
      end
    end
  end

  assign o_c = r_c;
  assign o_n = N_out;
  assign o_v = V_out;
  assign o_z = Z_out;

endmodule

// File: rtl/risc_cpu_regfile.sv
// Eight 16-bit general-purpose registers R0..R7, two combinational read
// ports and one synchronous write port.
module risc_cpu_regfile
  import risc_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic [2:0]  i_rd_addr_a,
  input  logic [2:0]  i_rd_addr_b,
  output logic [15:0] o_rd_a,
  output logic [15:0] o_rd_b
);

  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      R0 <= '0; R1 <= '0; R2 <= '0; R3 <= '0;
      R4 <= '0; R5 <= '0; R6 <= '0; R7 <= '0;
    end else if (i_wr_en) begin
      case (i_wr_addr)
        3'd0: R0 <= i_wr_data;
        3'd1: R1 <= i_wr_data;
        3'd2: R2 <= i_wr_data;
        3'd3: R3 <= i_wr_data;
        3'd4: R4 <= i_wr_data;
        3'd5: R5 <= i_wr_data;
        3'd6: R6 <= i_wr_data;
        default: R7 <= i_wr_data;
      endcase
    end
  end

  function automatic logic [15:0] rd_mux(input reg_idx_t idx,
      input logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7);
    logic [15:0] res;
    case (idx)
      3'd0: res = r0;
      3'd1: res = r1;
      3'd2: res = r2;
      3'd3: res = r3;
      3'd4: res = r4;
      3'd5: res = r5;
      3'd6: res = r6;
      default: res = r7;
    endcase
    return res;
  endfunction

  assign o_rd_a = rd_mux(i_rd_addr_a, R0, R1, R2, R3, R4, R5, R6, R7);
  assign o_rd_b = rd_mux(i_rd_addr_b, R0, R1, R2, R3, R4, R5, R6, R7);

endmodule

// File: rtl/risc_cpu.sv
// Multi-cycle 16-bit CPU top: instruction register and the sequencing FSM
// (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE) driving the datapath.
module risc_cpu
  import risc_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        N,
  output logic        V,
  output logic        Z,
  output logic        w
);

  state_e      r_state, w_next;
  logic [15:0] r_ir;
  logic [2:0]  w_opc;
  logic [1:0]  w_op, w_sh, w_alu_op;
  reg_idx_t    w_rn, w_rd, w_rm, w_wr_addr;
  logic        w_is_mov_imm, w_is_mov_reg, w_is_alu, w_is_cmp;
  logic        w_ld_a, w_ld_b, w_ld_c, w_ld_flags, w_wr_en, w_wr_imm;

  assign w_opc = r_ir[15:13];
  assign w_op  = r_ir[12:11];
  assign w_rn  = r_ir[10:8];
  assign w_rd  = r_ir[7:5];
  assign w_sh  = r_ir[4:3];
  assign w_rm  = r_ir[2:0];

  assign w_is_mov_imm = (w_opc == OPC_MOV) && (w_op == MOV_IMM);
  assign w_is_mov_reg = (w_opc == OPC_MOV) && (w_op == MOV_REG);
  assign w_is_alu     = (w_opc == OPC_ALU);
  assign w_is_cmp     = w_is_alu && (w_op == ALU_CMP);
  // MOV reg reuses the adder with a zeroed A operand so flags come out right
  assign w_alu_op     = w_is_mov_reg ? ALU_ADD : w_op;
  assign w_wr_addr    = w_is_mov_imm ? w_rn : w_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && load) r_ir <= in;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ld_a     = 1'b0;
    w_ld_b     = 1'b0;
    w_ld_c     = 1'b0;
    w_ld_flags = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_imm   = 1'b0;
    case (r_state)
      S_WAIT: if (s) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_mov_imm)                  w_next = S_WRITE_IMM;
        else if (w_is_mov_reg || w_is_alu) w_next = S_GET_A;
        else                               w_next = S_WAIT;
      end
      S_WRITE_IMM: begin
        w_wr_en  = 1'b1;
        w_wr_imm = 1'b1;
        w_next   = S_WAIT;
      end
      S_GET_A: begin
        w_ld_a = 1'b1;
        w_next = S_GET_B;
      end
      S_GET_B: begin
        w_ld_b = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_ld_c     = 1'b1;
        w_ld_flags = 1'b1;
        w_next     = w_is_cmp ? S_WAIT : S_WRITE;
      end
      S_WRITE: begin
        w_wr_en = 1'b1;
        w_next  = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

  risc_cpu_datapath DP (
    .clk         (clk),
    .reset       (reset),
    .i_a_zero    (w_is_mov_reg),
    .i_ld_a      (w_ld_a),
    .i_ld_b      (w_ld_b),
    .i_ld_c      (w_ld_c),
    .i_ld_flags  (w_ld_flags),
    .i_alu_op    (w_alu_op),
    .i_sh        (w_sh),
    .i_wr_en     (w_wr_en),
    .i_wr_imm    (w_wr_imm),
    .i_wr_addr   (w_wr_addr),
    .i_rd_addr_a (w_rn),
    .i_rd_addr_b (w_rm),
    .i_imm8      (r_ir[7:0]),
    .o_c         (out),
    .o_n         (N),
    .o_v         (V),
    .o_z         (Z)
  );

  assign w = (r_state == S_WAIT);

endmodule

// File: tb/tb_risc_cpu.sv
// Scoreboard bench for risc_cpu: directed program plus random instructions,
// checked against an arithmetic reference model on every return to WAIT.
module tb_risc_cpu;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in, out;
  logic        N, V, Z, w;

  risc_cpu dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .load  (load),
    .in    (in),
    .out   (out),
    .N     (N),
    .V     (V),
    .Z     (Z),
    .w     (w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][15:0] regs;
    logic [15:0]      c;
    logic             n, v, z;
    logic [7:0]       lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_r[8];
  logic [15:0] m_c, m_ir;
  logic        m_n, m_v, m_z;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dut_regs();
    logic [7:0][15:0] r;
    r = {dut.DP.REGFILE.R7, dut.DP.REGFILE.R6, dut.DP.REGFILE.R5, dut.DP.REGFILE.R4,
         dut.DP.REGFILE.R3, dut.DP.REGFILE.R2, dut.DP.REGFILE.R1, dut.DP.REGFILE.R0};
    return r;
  endfunction

  function automatic logic [15:0] shft(input logic [15:0] b, input int sh);
    case (sh)
      0: return b;
      1: return 16'(int'(b) * 2);
      2: return 16'(int'(b) / 2);
      default: return 16'($signed(b) >>> 1);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_c = 0; m_n = 0; m_v = 0; m_z = 0; m_ir = 0;
  endtask

  // Executes one instruction on the architectural model and snapshots the state
  task automatic model(input logic [15:0] ins, output exp_t e);
    int opc, op, rn, rd, sh, rm, sa, sb, sr;
    logic [15:0] a, bs, res;
    logic vv;
    opc = int'(ins[15:13]); op = int'(ins[12:11]);
    rn = int'(ins[10:8]); rd = int'(ins[7:5]); sh = int'(ins[4:3]); rm = int'(ins[2:0]);
    e.lat = 8'd1;
    if (opc == 6 && op == 2) begin
      m_r[rn] = 16'(int'($signed(ins[7:0])));
      e.lat = 8'd2;
    end else if ((opc == 6 && op == 0) || opc == 5) begin
      a  = (opc == 6) ? 16'h0000 : m_r[rn];
      bs = shft(m_r[rm], sh);
      sa = int'($signed(a));
      sb = int'($signed(bs));
      vv = 1'b0;
      if (opc == 6 || op == 0) begin
        sr = sa + sb; res = 16'(sr); vv = (sr > 32767) || (sr < -32768);
      end else if (op == 1) begin
        sr = sa - sb; res = 16'(sr); vv = (sr > 32767) || (sr < -32768);
      end else if (op == 2) res = a & bs;
      else res = ~bs;
      m_c = res; m_z = (res == 0); m_n = res[15]; m_v = vv;
      if (opc == 5 && op == 1) e.lat = 8'd4;
      else begin
        m_r[rd] = res;
        e.lat = 8'd5;
      end
    end
    for (int i = 0; i < 8; i++) e.regs[i] = m_r[i];
    e.c = m_c; e.n = m_n; e.v = m_v; e.z = m_z;
  endtask

  // Monitor: every WAIT re-entry retires one scoreboard entry
  initial begin : monitor
    logic prev_w;
    int   lowcnt;
    exp_t e;
    prev_w = 1'b1;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_w = 1'b1;
        lowcnt = 0;
      end else begin
        if (w && !prev_w) begin
          if (q.size() == 0) chk("unexpected_completion", 1, 0);
          else begin
            e = q.pop_front();
            chk("regs", dut_regs(), e.regs);
            chk("out", out, e.c);
            chk("flags_nvz", {N, V, Z}, {e.n, e.v, e.z});
            chk("busy_cycles", lowcnt, e.lat);
          end
        end
        lowcnt = w ? 0 : lowcnt + 1;
        prev_w = w;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!w && n < 40) begin @(negedge clk); n++; end
    chk("ready_wait", w, 1);
  endtask

  task automatic issue(input logic [15:0] ins, input bit do_load, input bit disturb);
    exp_t e;
    wait_ready();
    if (do_load) m_ir = ins;
    model(m_ir, e);
    q.push_back(e);
    if (do_load) begin
      in = ins; load = 1'b1; @(negedge clk); load = 1'b0;
    end
    s = 1'b1; @(negedge clk); s = 1'b0;
    if (disturb) begin
      load = 1'b1; in = 16'($urandom); s = 1'b1;
      @(negedge clk);
      load = 1'b0; s = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !w) && n < 200) begin @(negedge clk); n++; end
    chk("drain", q.size() == 0, 1);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    int k;
    k = $urandom_range(0, 6);
    r = 16'($urandom);
    case (k)
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2, 3, 4, 5: r[15:11] = {3'b101, 2'(k - 2)};
      default: begin
        while (r[15:13] == 3'b101 || (r[15:13] == 3'b110 && r[11] == 1'b0))
          r = 16'($urandom);
      end
    endcase
    return r;
  endfunction

  initial begin
    logic [15:0] p1[8];
    logic [15:0] p2[3];
    logic [15:0] p3[3];
    p1 = '{16'hD002, 16'hD101, 16'hA041, 16'hB06A, 16'hC06A, 16'hB880, 16'hAA02, 16'hA8E8};
    p2 = '{16'hD5FF, 16'hD680, 16'hA6E5};
    p3 = '{16'hD7FE, 16'hC02F, 16'hA2A4};
    model_reset();
    reset = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0;
    @(negedge clk); @(negedge clk);
    chk("reset_w", w, 1);
    chk("reset_out", out, 0);
    chk("reset_flags", {N, V, Z}, 0);
    chk("reset_regs", dut_regs(), 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (p1[i]) issue(p1[i], 1'b1, 1'b0);
    wait_idle();
    chk("lit_R0", dut.DP.REGFILE.R0, 16'h0002);
    chk("lit_R1", dut.DP.REGFILE.R1, 16'h0001);
    chk("lit_R2", dut.DP.REGFILE.R2, 16'h0003);
    chk("lit_R3", dut.DP.REGFILE.R3, 16'h0006);
    chk("lit_R4", dut.DP.REGFILE.R4, 16'hFFFD);
    chk("lit_cmp_nvz", {dut.DP.N_out, dut.DP.V_out, dut.DP.Z_out}, 3'b100);

    foreach (p2[i]) issue(p2[i], 1'b1, 1'b1);
    wait_idle();
    chk("lit_R5", dut.DP.REGFILE.R5, 16'hFFFF);
    chk("lit_R6", dut.DP.REGFILE.R6, 16'hFF80);
    chk("lit_R7", dut.DP.REGFILE.R7, 16'hFF7F);
    chk("lit_add_n", N, 1);

    foreach (p3[i]) issue(p3[i], 1'b1, 1'b0);
    wait_idle();
    chk("lit_R1_lsl", dut.DP.REGFILE.R1, 16'hFFFC);
    chk("lit_R5_wrap", dut.DP.REGFILE.R5, 16'h0000);
    chk("lit_wrap_z", Z, 1);

    // Abort an ADD while it sits in EXEC
    wait_ready();
    in = 16'hA041; load = 1'b1; @(negedge clk); load = 1'b0;
    s = 1'b1; @(negedge clk); s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_before_reset", w, 0);
    reset = 1'b0;
    #1;
    model_reset();
    chk("abort_w", w, 1);
    chk("abort_out", out, 0);
    chk("abort_flags", {N, V, Z}, 0);
    chk("abort_regs", dut_regs(), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) issue(rand_instr(), 1'b1, 1'($urandom_range(0, 1)));
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
